alu_seq_muldiv: RTL and testbench
=================================

Name: alu_seq_muldiv

Overview:
- Parametrised successor to the single-cycle ALU: same base ops and flags (ALU_Out, CarryOut, ZeroOut), plus iterative multiply and divide/remainder (RV32M semantics).
- Valid/ready handshakes on input and output, so a multi-cycle RV core can stall on it.
- Sits in the execute stage, between the register-read operands and writeback.

Parameters:
- WIDTH, 32, operand/result width; must be ≥8 and a power of two. Localparam SHAMT_W = $clog2(WIDTH).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand/op valid
- in_ready  out  1  block can accept a new operation
- A  in  WIDTH  operand A (rs1)
- B  in  WIDTH  operand B (rs2); shifts use B[SHAMT_W-1:0]
- ALU_Sel  in  5  operation select
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  consumer takes result
- ALU_Out  out  WIDTH  registered result
- CarryOut  out  1  carry/no-borrow from ADD/SUB; 0 for all other ops
- ZeroOut  out  1  ALU_Out == 0
- IllegalOp  out  1  ALU_Sel was unassigned

Behaviour:
- Op encoding:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR
  - 00101 SLL, 00110 SRL, 00111 SRA, 01000 SLT, 01001 SLTU
  - 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU
  - All other codes are illegal.
- Reset: state IDLE; out_valid=0, ALU_Out=0, CarryOut=0, ZeroOut=0, IllegalOp=0, iteration counter=0. in_ready=0 while reset is high.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept when in_valid & in_ready.
- FSM states: IDLE, CALC, FIX, DONE.
- Base op or illegal op, accepted at edge N: result computed combinationally and registered; state becomes DONE at edge N, so out_valid is high from edge N (latency 1).
- Mul/div accepted at edge N:
  - Operands are converted to magnitudes; state becomes CALC; counter=0.
  - CALC runs WIDTH iterations: shift-add for MUL, restoring shift-subtract for DIV.
  - FIX applies sign correction and selects the high or low half.
  - DONE is reached at edge N+WIDTH+1, so out_valid rises WIDTH+2 edges after acceptance. Latency is fixed and independent of data.
- DONE: outputs are held stable while out_ready=0. When out_ready=1, either a new op is accepted in the same cycle (back-to-back) or the state returns to IDLE.
- Arithmetic:
  - ADD CarryOut = carry out of the MSB.
  - SUB computes A + ~B + 1; CarryOut = 1 iff A ≥ B unsigned.
  - SLT/SLTU return 0 or 1, zero-extended.
  - Products are computed at 2·WIDTH. MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- Boundaries:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → A.
  - Signed overflow (DIV of most-negative by -1): quotient = most-negative, remainder = 0.
  - Both cases still take the full latency and are overridden in FIX.
- Illegal op: ALU_Out=0, IllegalOp=1, latency 1.
- in_valid while busy (CALC/FIX) is ignored; the operand is not captured.
- Reset asserted mid-operation aborts the operation. The next edge is as at reset and no stale result is ever presented.

Optional Feature:
- ALU_DIV_EN defined: DIV/DIVU/REM/REMU are implemented as above.
- ALU_DIV_EN undefined: the divider datapath is removed. Codes 10100–10111 are illegal (IllegalOp=1, ALU_Out=0, latency 1). MUL ops are unchanged.

Decomposition:
- Package alu_pkg:
  - op-code localparams (OP_ADD … OP_REMU)
  - FSM state enum
  - helper function is_muldiv(op)
- Sub-module alu_muldiv_seq: iterative multiply/divide datapath with start/done, counter, partial-remainder and product registers. The top level holds the base ALU, FSM and handshakes.

Test Plan:
- ADD A=2, B=2 → ALU_Out=4, CarryOut=0, ZeroOut=0; out_valid 1 edge after accept. ADD 0xFFFFFFFF+1 → 0, CarryOut=1, ZeroOut=1.
- SUB A=5, B=5 → 0, ZeroOut=1, CarryOut=1. SLT A=0xFFFFFFFF, B=1 → 1; SLTU on the same operands → 0; SRA 0x80000000 by 4 → 0xF8000000.
- MUL A=0x80000000, B=2 → 0x00000000; MULH on the same operands → 0xFFFFFFFF; MULHU → 0x00000001. out_valid exactly 34 edges after accept (WIDTH=32).
- DIV -7/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF. DIV 9/0 → 0xFFFFFFFF; REMU 9/0 → 9. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Backpressure: hold out_ready=0 for 5 cycles after a MUL result → ALU_Out/flags stable, in_ready=0. Raise out_ready with in_valid (ADD 1+1) → accepted the same edge, 2 presented next edge.
- Reset at cycle 10 of a DIV → out_valid=0 the next edge, in_ready=1 after release, no DIV result ever presented. Illegal ALU_Sel=11111 → IllegalOp=1, ALU_Out=0 (also 10100 with ALU_DIV_EN undefined).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op-code map, FSM state type and op classification for the sequential ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00001;
  localparam logic [4:0] OP_AND    = 5'b00010;
  localparam logic [4:0] OP_OR     = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_SLL    = 5'b00101;
  localparam logic [4:0] OP_SRL    = 5'b00110;
  localparam logic [4:0] OP_SRA    = 5'b00111;
  localparam logic [4:0] OP_SLT    = 5'b01000;
  localparam logic [4:0] OP_SLTU   = 5'b01001;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Codes 10000..10111 are the iterative multiply/divide group.
  function automatic logic is_muldiv(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply (shift-add) and divide (restoring) datapath, one bit per cycle.
// The divider is only built when ALU_DIV_EN is defined.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [1:0]       var_q, var_d;
  logic             res_neg_q, res_neg_d;

  logic             is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0] mul_res;

`ifdef ALU_DIV_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic             div_q, div_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dvz_q, dvz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH:0]   div_shift, div_trial;
  logic [WIDTH-1:0] quo, rem;

  assign is_div = op[2];
`else
  logic unused_div_sel;
  assign unused_div_sel = op[2];
  assign is_div         = 1'b0;
`endif

  // Signedness of each operand by variant: MUL/MULH/MULHSU sign A, MUL/MULH sign B.
  assign a_sgn = is_div ? ~op[0] : (op[1:0] != 2'b11);
  assign b_sgn = is_div ? ~op[0] : ~op[1];
  assign a_neg = a_sgn & a[WIDTH-1];
  assign b_neg = b_sgn & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + ONE) : a;
  assign b_mag = b_neg ? (~b + ONE) : b;

  assign last    = busy_q & (cnt_q == CNT_W'(WIDTH-1));
  assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);

`ifdef ALU_DIV_EN
  assign div_shift = {acc_q, lo_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, dvs_q};
`endif

  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    dvs_d     = dvs_q;
    var_d     = var_q;
    res_neg_d = res_neg_q;
`ifdef ALU_DIV_EN
    div_d     = div_q;
    rem_neg_d = rem_neg_q;
    dvz_d     = dvz_q;
    ovf_d     = ovf_q;
    a_raw_d   = a_raw_q;
`endif
    if (start) begin
      busy_d    = 1'b1;
      cnt_d     = '0;
      acc_d     = '0;
      lo_d      = a_mag;
      dvs_d     = b_mag;
      var_d     = op[1:0];
      res_neg_d = a_neg ^ b_neg;
`ifdef ALU_DIV_EN
      div_d     = is_div;
      rem_neg_d = a_neg;
      dvz_d     = (b == '0);
      ovf_d     = a_sgn & (a == MIN_NEG) & (b == '1);
      a_raw_d   = a;
`endif
    end else if (busy_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (last) busy_d = 1'b0;
`ifdef ALU_DIV_EN
      if (div_q) begin
        // Restoring step: keep the trial difference only when it did not borrow.
        if (!div_trial[WIDTH]) begin
          acc_d = div_trial[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = div_shift[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = mul_sum[WIDTH:1];
        lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
`else
      acc_d = mul_sum[WIDTH:1];
      lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
`endif
    end
  end

  // Sign fix-up and half selection, consumed by the top during its FIX state.
  always_comb begin
    prod_mag = {acc_q, lo_q};
    prod     = res_neg_q ? (~prod_mag + (2*WIDTH)'(1)) : prod_mag;
    mul_res  = (var_q == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
`ifdef ALU_DIV_EN
    quo = res_neg_q ? (~lo_q + ONE) : lo_q;
    rem = rem_neg_q ? (~acc_q + ONE) : acc_q;
    if (dvz_q) begin
      quo = '1;
      rem = a_raw_q;
    end else if (ovf_q) begin
      quo = MIN_NEG;
      rem = '0;
    end
    result = div_q ? (var_q[1] ? rem : quo) : mul_res;
`else
    result = mul_res;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    lo_q      <= lo_d;
    dvs_q     <= dvs_d;
    var_q     <= var_d;
    res_neg_q <= res_neg_d;
`ifdef ALU_DIV_EN
    div_q     <= div_d;
    rem_neg_q <= rem_neg_d;
    dvz_q     <= dvz_d;
    ovf_q     <= ovf_d;
    a_raw_q   <= a_raw_d;
`endif
  end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Execute-stage ALU with valid/ready handshakes: single-cycle base ops plus iterative
// RV32M multiply; divide/remainder are present only when ALU_DIV_EN is defined.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             ZeroOut,
  output logic             IllegalOp
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic             accept, md_op, md_last;
  logic [WIDTH-1:0] md_result;
  logic [WIDTH-1:0] base_res;
  logic             base_carry, base_ill;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH:0]   add_sum, sub_sum;
  logic [SHAMT_W-1:0] shamt;

`ifdef ALU_DIV_EN
  assign md_op = is_muldiv(ALU_Sel);
`else
  assign md_op = is_muldiv(ALU_Sel) & ~ALU_Sel[2];
`endif

  assign a_s     = A;
  assign b_s     = B;
  assign shamt   = B[SHAMT_W-1:0];
  assign add_sum = {1'b0, A} + {1'b0, B};
  // Bit WIDTH of A + ~B + 1 is the no-borrow flag, i.e. A >= B unsigned.
  assign sub_sum = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);

  always_comb begin
    base_res   = '0;
    base_carry = 1'b0;
    base_ill   = 1'b0;
    case (ALU_Sel)
      OP_ADD:  begin base_res = add_sum[WIDTH-1:0]; base_carry = add_sum[WIDTH]; end
      OP_SUB:  begin base_res = sub_sum[WIDTH-1:0]; base_carry = sub_sum[WIDTH]; end
      OP_AND:  base_res = A & B;
      OP_OR:   base_res = A | B;
      OP_XOR:  base_res = A ^ B;
      OP_SLL:  base_res = A << shamt;
      OP_SRL:  base_res = A >> shamt;
      OP_SRA:  base_res = a_s >>> shamt;
      OP_SLT:  base_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: base_res = {{(WIDTH-1){1'b0}}, (A < B)};
      default: base_ill = 1'b1;
    endcase
  end

  alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (accept & md_op),
    .op     (ALU_Sel[2:0]),
    .a      (A),
    .b      (B),
    .last   (md_last),
    .result (md_result)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = md_op ? ST_CALC : ST_DONE;
      ST_CALC: if (md_last) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = accept ? (md_op ? ST_CALC : ST_DONE) : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A result in DONE may be retired and replaced on the same edge.
  always_comb begin
    in_ready  = ~reset & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
    out_valid = (state_q == ST_DONE);
    accept    = in_valid & in_ready;
  end

  always_comb begin
    alu_out_d = alu_out_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (accept & ~md_op) begin
      alu_out_d = base_res;
      carry_d   = base_carry;
      zero_d    = (base_res == '0);
      illegal_d = base_ill;
    end else if (state_q == ST_FIX) begin
      alu_out_d = md_result;
      carry_d   = 1'b0;
      zero_d    = (md_result == '0);
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_out_q <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign ALU_Out   = alu_out_q;
  assign CarryOut  = carry_q;
  assign ZeroOut   = zero_q;
  assign IllegalOp = illegal_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Scoreboard bench for alu_seq_muldiv: driver pushes model results, monitor pops on handshake.
module tb_alu_seq_muldiv;

  localparam int W      = 32;
  localparam int MD_LAT = W + 1;
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready;
  logic         CarryOut, ZeroOut, IllegalOp;
  logic [W-1:0] A, B, ALU_Out;
  logic [4:0]   ALU_Sel;

  int     nvec = 0;
  int     nerr = 0;
  longint cyc = 0;
  bit     flushing = 1'b1;
  bit     rdy_rand = 1'b0;
  bit     seen = 1'b0;

  typedef struct {
    logic [W-1:0] res;
    logic         carry;
    logic         ill;
    int           lat;
    longint       vcyc;
  } exp_t;

  exp_t sbq[$];

  logic [4:0] legal_ops [18] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                                 5'h08, 5'h09, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15,
                                 5'h16, 5'h17};

  alu_seq_muldiv #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALU_Sel   (ALU_Sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALU_Out   (ALU_Out),
    .CarryOut  (CarryOut),
    .ZeroOut   (ZeroOut),
    .IllegalOp (IllegalOp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour from the RV32M arithmetic rules, using 64-bit integer math.
  function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic [W:0]  s;
    int          sh;
    e.res = '0; e.carry = 1'b0; e.ill = 1'b0; e.lat = 0; e.vcyc = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sh = int'(b[4:0]);
    case (op)
      5'h00: begin s = {1'b0, a} + {1'b0, b}; e.res = s[W-1:0]; e.carry = s[W]; end
      5'h01: begin e.res = a - b; e.carry = (a >= b); end
      5'h02: e.res = a & b;
      5'h03: e.res = a | b;
      5'h04: e.res = a ^ b;
      5'h05: e.res = a << sh;
      5'h06: e.res = a >> sh;
      5'h07: e.res = $signed(a) >>> sh;
      5'h08: e.res = W'(sa < sb);
      5'h09: e.res = W'(ua < ub);
      5'h10: begin p = 64'(sa * sb); e.res = p[31:0];  e.lat = MD_LAT; end
      5'h11: begin p = 64'(sa * sb); e.res = p[63:32]; e.lat = MD_LAT; end
      5'h12: begin p = 64'(sa * ub); e.res = p[63:32]; e.lat = MD_LAT; end
      5'h13: begin p = 64'(ua * ub); e.res = p[63:32]; e.lat = MD_LAT; end
      5'h14, 5'h15, 5'h16, 5'h17: begin
        if (!DIV_EN) e.ill = 1'b1;
        else begin
          e.lat = MD_LAT;
          case (op[1:0])
            2'b00: e.res = (b == 0) ? '1 : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : W'(sa / sb);
            2'b01: e.res = (b == 0) ? '1 : a / b;
            2'b10: e.res = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? '0 : W'(sa % sb);
            default: e.res = (b == 0) ? a : a % b;
          endcase
        end
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = model(op, a, b);
    ALU_Sel  = op;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.vcyc = cyc + 1 + e.lat;
        sbq.push_back(e);
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    nvec++; nerr++;
    $display("FAIL accept-timeout: in_ready never rose for op %b", op);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && sbq.size() != 0; t++) tick();
    nvec++;
    if (sbq.size() != 0) begin
      nerr++;
      $display("FAIL drain-timeout: %0d results still pending, expected 0", sbq.size());
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    flushing = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("reset-out_valid", out_valid, 0);
    chk("reset-in_ready", in_ready, 0);
    chk("reset-ALU_Out", ALU_Out, 0);
    chk("reset-CarryOut", CarryOut, 0);
    chk("reset-ZeroOut", ZeroOut, 0);
    chk("reset-IllegalOp", IllegalOp, 0);
    sbq.delete();
    reset = 1'b0;
    #1;
    chk("post-reset-in_ready", in_ready, 1);
    tick();
    flushing = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom_range(0, 15));
      default: return W'($urandom());
    endcase
  endfunction

  always @(negedge clk) begin
    if (flushing) seen = 1'b0;
    else if (out_valid) begin
      if (sbq.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected-result: ALU_Out=%0h presented, expected no result", ALU_Out);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("latency-cycle", 64'(cyc), 64'(sbq[0].vcyc));
        end
        chk("ALU_Out", ALU_Out, sbq[0].res);
        chk("CarryOut", CarryOut, sbq[0].carry);
        chk("ZeroOut", ZeroOut, sbq[0].res == 0);
        chk("IllegalOp", IllegalOp, sbq[0].ill);
        if (!out_ready) chk("stall-in_ready", in_ready, 0);
        else begin
          void'(sbq.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; ALU_Sel = '0;
    do_reset();

    issue(5'h00, 32'd2, 32'd2);
    issue(5'h00, 32'hFFFF_FFFF, 32'd1);
    issue(5'h01, 32'd5, 32'd5);
    issue(5'h08, 32'hFFFF_FFFF, 32'd1);
    issue(5'h09, 32'hFFFF_FFFF, 32'd1);
    issue(5'h07, 32'h8000_0000, 32'd4);
    issue(5'h10, 32'h8000_0000, 32'd2);
    issue(5'h11, 32'h8000_0000, 32'd2);
    issue(5'h13, 32'h8000_0000, 32'd2);
    issue(5'h14, 32'hFFFF_FFF9, 32'd2);
    issue(5'h16, 32'hFFFF_FFF9, 32'd2);
    issue(5'h14, 32'd9, 32'd0);
    issue(5'h17, 32'd9, 32'd0);
    issue(5'h14, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(5'h16, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(5'h1F, 32'd3, 32'd4);
    issue(5'h0C, 32'd3, 32'd4);
    drain();

    // Backpressure on a MUL result, then a same-edge back-to-back ADD.
    out_ready = 1'b0;
    issue(5'h11, 32'h8000_0000, 32'd2);
    for (int t = 0; t < 100 && !out_valid; t++) tick();
    chk("mul-result-presented", out_valid, 1);
    repeat (5) tick();
    out_ready = 1'b1;
    issue(5'h00, 32'd1, 32'd1);
    drain();

    // Reset ten cycles into a divide; its result must never appear.
    issue(5'h14, 32'd100, 32'd7);
    repeat (9) tick();
    do_reset();
    repeat (40) tick();
    issue(5'h00, 32'd3, 32'd4);
    drain();

    rdy_rand = 1'b1;
    for (int n = 0; n < 250; n++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : legal_ops[$urandom_range(0, 17)];
      issue(op, rnd_operand(), rnd_operand());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    rdy_rand  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
